// File: rtl/infra_emitter.sv
`default_nettype none
// ----------------------------------------------------------------------------
// infra_emitter: IR ball-detect emitter, gated carrier bursts with end-of-burst
// receiver sampling and blocked-beam detection.            Rev 1.0
// ----------------------------------------------------------------------------
module infra_emitter #(
  parameter int HALF_PERIOD  = 13,
  parameter int BURST_PULSES = 10,
  parameter int GAP_CYCLES   = 200,
  parameter int BLOCK_THRESH = 3
) (
  input  logic clk,
  input  logic rst_n,
  input  logic en,
  input  logic rx_bit,
  output logic ir_out,
  output logic burst_active,
  output logic sample_stb,
  output logic beam_seen,
  output logic beam_blocked,
  output logic busy
);

  localparam int PW = (HALF_PERIOD  > 1) ? $clog2(HALF_PERIOD)  : 1;
  localparam int CW = (BURST_PULSES > 1) ? $clog2(BURST_PULSES) : 1;
  localparam int GW = (GAP_CYCLES   > 1) ? $clog2(GAP_CYCLES)   : 1;

  localparam logic [PW-1:0] C_PHASE_LAST = PW'(HALF_PERIOD - 1);
  localparam logic [CW-1:0] C_PULSE_LAST = CW'(BURST_PULSES - 1);
  localparam logic [GW-1:0] C_GAP_LAST   = GW'(GAP_CYCLES - 1);
  localparam logic [3:0]    C_THRESH     = 4'(BLOCK_THRESH);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    BURST = 2'd1,
    GAP   = 2'd2
  } state_t;

  state_t        r_state;
  logic [PW-1:0] r_phase;
  logic [CW-1:0] r_pulse;
  logic [GW-1:0] r_gap;
  logic [3:0]    r_miss;

  logic          w_half_end;
  logic [PW-1:0] w_phase_nx;
  logic [CW-1:0] w_pulse_nx;
  logic          w_ir_nx;
  logic          w_final_nx;
  logic [3:0]    w_miss_inc;

  // Carrier level doubles as the half-period marker: low half closes a period.
  always_comb begin
    w_half_end = (r_phase == C_PHASE_LAST);
    w_phase_nx = w_half_end ? '0 : r_phase + 1'b1;
    w_ir_nx    = w_half_end ? ~ir_out : ir_out;
    w_pulse_nx = (w_half_end && !ir_out) ? r_pulse + 1'b1 : r_pulse;
    w_final_nx = (w_phase_nx == C_PHASE_LAST) && (w_pulse_nx == C_PULSE_LAST) && !w_ir_nx;
    w_miss_inc = (r_miss == 4'hF) ? r_miss : r_miss + 4'd1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= IDLE;
      r_phase      <= '0;
      r_pulse      <= '0;
      r_gap        <= '0;
      r_miss       <= '0;
      ir_out       <= 1'b0;
      burst_active <= 1'b0;
      sample_stb   <= 1'b0;
      beam_seen    <= 1'b0;
      beam_blocked <= 1'b0;
      busy         <= 1'b0;
    end else begin
      sample_stb <= 1'b0;
      unique case (r_state)
        IDLE: begin
          if (en) begin
            r_state      <= BURST;
            r_phase      <= '0;
            r_pulse      <= '0;
            r_gap        <= '0;
            ir_out       <= 1'b1;
            burst_active <= 1'b1;
            busy         <= 1'b1;
          end
        end
        BURST: begin
          // sample_stb marks the current cycle as the final one of the burst
          if (sample_stb) begin
            r_state      <= GAP;
            r_gap        <= '0;
            ir_out       <= 1'b0;
            burst_active <= 1'b0;
            beam_seen    <= rx_bit;
            if (rx_bit) begin
              r_miss       <= '0;
              beam_blocked <= 1'b0;
            end else begin
              r_miss       <= w_miss_inc;
              beam_blocked <= (w_miss_inc >= C_THRESH);
            end
          end else begin
            r_phase    <= w_phase_nx;
            r_pulse    <= w_pulse_nx;
            ir_out     <= w_ir_nx;
            sample_stb <= w_final_nx;
          end
        end
        GAP: begin
          if (r_gap == C_GAP_LAST) begin
            if (en) begin
              r_state      <= BURST;
              r_phase      <= '0;
              r_pulse      <= '0;
              r_gap        <= '0;
              ir_out       <= 1'b1;
              burst_active <= 1'b1;
            end else begin
              r_state <= IDLE;
              busy    <= 1'b0;
            end
          end else begin
            r_gap <= r_gap + 1'b1;
          end
        end
        default: begin
          r_state      <= IDLE;
          ir_out       <= 1'b0;
          burst_active <= 1'b0;
          busy         <= 1'b0;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_infra_emitter.sv
`default_nettype none
// ----------------------------------------------------------------------------
// tb_infra_emitter: scoreboard bench against a burst-position reference model.
// Rev 1.0
// ----------------------------------------------------------------------------
module tb_infra_emitter;

  localparam int HP        = 2;
  localparam int BP        = 3;
  localparam int GP        = 5;
  localparam int TH        = 3;
  localparam int BURST_LEN = 2 * HP * BP;
  localparam int PERIOD    = BURST_LEN + GP;

  logic clk    = 1'b0;
  logic rst_n  = 1'b0;
  logic en     = 1'b0;
  logic rx_bit = 1'b0;
  logic ir_out, burst_active, sample_stb, beam_seen, beam_blocked, busy;

  always #5 clk = ~clk;

  infra_emitter #(
    .HALF_PERIOD (HP),
    .BURST_PULSES(BP),
    .GAP_CYCLES  (GP),
    .BLOCK_THRESH(TH)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .en          (en),
    .rx_bit      (rx_bit),
    .ir_out      (ir_out),
    .burst_active(burst_active),
    .sample_stb  (sample_stb),
    .beam_seen   (beam_seen),
    .beam_blocked(beam_blocked),
    .busy        (busy)
  );

  int n_checks  = 0;
  int n_fail    = 0;
  int n_samples = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: position within the 17-cycle burst+gap period.
  typedef struct {
    bit seen;
    bit blocked;
  } exp_t;

  exp_t sb_q[$];
  bit   m_active = 1'b0;
  int   m_pos    = 0;
  int   m_miss   = 0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_active = 1'b0;
      m_pos    = 0;
      m_miss   = 0;
      sb_q.delete();
    end else begin
      if (m_active && m_pos == BURST_LEN - 1) begin
        if (rx_bit) m_miss = 0;
        else        m_miss = (m_miss < 15) ? m_miss + 1 : 15;
        sb_q.push_back('{seen: rx_bit, blocked: (m_miss >= TH)});
      end
      if (!m_active) begin
        if (en) begin
          m_active = 1'b1;
          m_pos    = 0;
        end
      end else if (m_pos == PERIOD - 1) begin
        if (en) m_pos = 0;
        else    m_active = 1'b0;
      end else begin
        m_pos++;
      end
    end
  end

  bit prev_stb = 1'b0;
  bit hold_seen = 1'b0;
  bit hold_blk  = 1'b0;
  bit mon_on    = 1'b1;

  always @(negedge clk) begin
    if (mon_on) begin
      automatic bit e_burst = m_active && (m_pos < BURST_LEN);
      automatic exp_t e;
      check("ir_out",       ir_out,       e_burst && ((m_pos % (2 * HP)) < HP));
      check("burst_active", burst_active, e_burst);
      check("sample_stb",   sample_stb,   m_active && (m_pos == BURST_LEN - 1));
      check("busy",         busy,         m_active);
      if (!rst_n) begin
        prev_stb  = 1'b0;
        hold_seen = 1'b0;
        hold_blk  = 1'b0;
      end else if (prev_stb) begin
        check("sb_depth", sb_q.size() > 0, 1);
        if (sb_q.size() > 0) begin
          e = sb_q.pop_front();
          hold_seen = e.seen;
          hold_blk  = e.blocked;
          n_samples++;
        end
      end
      check("beam_seen",    beam_seen,    hold_seen);
      check("beam_blocked", beam_blocked, hold_blk);
      prev_stb = sample_stb && rst_n;
    end
  end

  // mode: 0 = beam blocked, 1 = beam seen, 2 = random per burst
  task automatic run_bursts(input int n, input int mode);
    for (int i = 0; i < n; i++) begin
      rx_bit = (mode == 2) ? 1'($urandom_range(0, 1)) : 1'(mode);
      repeat (PERIOD) @(negedge clk);
    end
  endtask

  initial begin
    int w;
    rst_n  = 1'b0;
    en     = 1'b1;
    rx_bit = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_ir_out",       ir_out,       0);
    check("rst_beam_seen",    beam_seen,    0);
    check("rst_beam_blocked", beam_blocked, 0);
    check("rst_busy",         busy,         0);
    rst_n = 1'b1;
    @(negedge clk);
    check("first_ir_after_release", ir_out, 1);
    run_bursts(3, 1);
    run_bursts(4, 0);
    run_bursts(1, 1);
    run_bursts(20, 0);
    check("saturated_blocked", beam_blocked, 1);
    run_bursts(1, 1);
    check("cleared_blocked", beam_blocked, 0);
    run_bursts(10, 2);

    // shutdown mid-burst: burst and gap must still complete
    repeat (5) @(negedge clk);
    en = 1'b0;
    repeat (20) @(negedge clk);
    check("shutdown_busy",   busy,   0);
    check("shutdown_ir_out", ir_out, 0);
    check("sample_count", n_samples, 40);

    // asynchronous reset between edges while the LED is lit
    en = 1'b1;
    w  = 0;
    while (!ir_out && w < 20) begin
      @(negedge clk);
      w++;
    end
    check("ir_rise_before_async_rst", ir_out, 1);
    @(posedge clk);
    #2;
    check("ir_high_mid_cycle", ir_out, 1);
    rst_n = 1'b0;
    #1;
    check("async_rst_ir_out",       ir_out,       0);
    check("async_rst_burst_active", burst_active, 0);
    check("async_rst_busy",         busy,         0);
    @(negedge clk);
    mon_on = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
